// File: rtl/dram_axi_burst_bridge_if.sv
// AXI4 bus between the DRAM burst bridge (master) and the MIG AXI slave.
// Carries the five AXI channels; the user-side port stays on plain module ports.
interface dram_axi_burst_bridge_if #(
  parameter int AXI_ADDR_W = 28,
  parameter int DATA_W     = 128,
  parameter int ID_W       = 4
);
  logic [ID_W-1:0]       awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_W-1:0]       arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;

  logic [ID_W-1:0]       rid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/dram_axi_burst_bridge.sv
// Converts one user-side memory command into a single AXI INCR burst of i_len+1 beats,
// streaming write beats, collecting the B response and checking RLAST/RRESP/BRESP.
module dram_axi_burst_bridge #(
  parameter int USR_ADDR_W = 27,
  parameter int AXI_ADDR_W = 28,
  parameter int ADDR_SHIFT = 1,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 4,
  parameter int ID_W       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_calib_done,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [USR_ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]      i_len,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wmask,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_rvalid,
  output logic                  o_rlast,
  output logic                  o_busy,
  output logic [2:0]            o_err,
  input  logic                  i_err_clr,
  dram_axi_burst_bridge_if.master s_axi
);

  localparam int         SHIFT_W  = USR_ADDR_W + ADDR_SHIFT;
  localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {
    CALIB, IDLE, WR, WR_RESP, RD, RD_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  awvalid_q, arvalid_q, aw_done_q;
  logic [8:0]            beat_cnt_q;  // one bit wider than len so len=255 can count past the end
  logic [2:0]            err_q, err_d, new_err;

  logic [SHIFT_W-1:0]    addr_wide;
  logic accept_wr, accept_rd;
  logic aw_fire, ar_fire, w_fire, r_fire, r_last_fire;
  logic aw_complete, w_complete, beat_is_last;
  logic w_open, bready, rready;

  assign addr_wide   = SHIFT_W'(i_addr) << ADDR_SHIFT;
  assign accept_wr   = (state_q == IDLE) && i_wr_en;
  assign accept_rd   = (state_q == IDLE) && !i_wr_en && i_rd_en;

  assign beat_is_last = (beat_cnt_q == {1'b0, len_q});
  assign aw_fire      = awvalid_q && s_axi.awready;
  assign ar_fire      = arvalid_q && s_axi.arready;
  assign w_fire       = s_axi.wvalid && s_axi.wready;
  assign r_fire       = s_axi.rvalid && rready;
  assign r_last_fire  = r_fire && s_axi.rlast;
  assign aw_complete  = aw_done_q || aw_fire;
  assign w_complete   = (beat_cnt_q > {1'b0, len_q}) || (w_fire && beat_is_last);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= CALIB;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CALIB:   if (i_calib_done) state_d = IDLE;
      IDLE: begin
        if (i_wr_en)      state_d = WR;
        else if (i_rd_en) state_d = RD;
      end
      WR:      if (aw_complete && w_complete) state_d = WR_RESP;
      WR_RESP: if (s_axi.bvalid) state_d = IDLE;
      RD: begin
        if (r_last_fire)  state_d = IDLE;
        else if (ar_fire) state_d = RD_DATA;
      end
      RD_DATA: if (r_last_fire) state_d = IDLE;
      default: state_d = CALIB;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    bready  = 1'b0;
    rready  = 1'b0;
    w_open  = 1'b0;
    unique case (state_q)
      IDLE:    o_ready = 1'b1;
      WR: begin
        o_busy = 1'b1;
        w_open = (beat_cnt_q <= {1'b0, len_q});
      end
      WR_RESP: begin
        o_busy = 1'b1;
        bready = 1'b1;
      end
      RD, RD_DATA: begin
        o_busy = 1'b1;
        rready = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Burst control registers ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      awvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      if (accept_wr)    awvalid_q <= 1'b1;
      else if (aw_fire) awvalid_q <= 1'b0;

      // An early RLAST ends the read, so AR must not stay asserted into IDLE.
      if (accept_rd)                   arvalid_q <= 1'b1;
      else if (ar_fire || r_last_fire) arvalid_q <= 1'b0;

      if (accept_wr)    aw_done_q <= 1'b0;
      else if (aw_fire) aw_done_q <= 1'b1;

      if (accept_wr || accept_rd) beat_cnt_q <= '0;
      else if (w_fire || r_fire)  beat_cnt_q <= beat_cnt_q + 9'd1;

      err_q <= err_d;
    end
  end

  // NOTE: address/length are loaded on every accepted command before use, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (accept_wr || accept_rd) begin
      addr_q <= AXI_ADDR_W'(addr_wide);
      len_q  <= 8'(i_len);
    end
  end

  // A new error in the same cycle as a clear wins, so no event is lost.
  always_comb begin
    new_err[0] = s_axi.bvalid && bready && (s_axi.bresp != 2'b00);
    new_err[1] = r_fire && (s_axi.rresp != 2'b00);
    new_err[2] = r_fire && (s_axi.rlast != beat_is_last);
    err_d      = (i_err_clr ? 3'b000 : err_q) | new_err;
  end

  assign o_err = err_q;

  // ---------------- AXI channel drive ----------------
  assign s_axi.awid    = '0;
  assign s_axi.awaddr  = addr_q;
  assign s_axi.awlen   = len_q;
  assign s_axi.awsize  = AXI_SIZE;
  assign s_axi.awburst = 2'b01;
  assign s_axi.awlock  = 1'b0;
  assign s_axi.awcache = 4'd0;
  assign s_axi.awprot  = 3'd0;
  assign s_axi.awqos   = 4'd0;
  assign s_axi.awvalid = awvalid_q;

  assign s_axi.wdata   = i_wdata;
  assign s_axi.wstrb   = ~i_wmask;
  assign s_axi.wlast   = beat_is_last;
  assign s_axi.wvalid  = i_wvalid && w_open;
  assign o_wready      = s_axi.wready && w_open;

  assign s_axi.bready  = bready;

  assign s_axi.arid    = '0;
  assign s_axi.araddr  = addr_q;
  assign s_axi.arlen   = len_q;
  assign s_axi.arsize  = AXI_SIZE;
  assign s_axi.arburst = 2'b01;
  assign s_axi.arlock  = 1'b0;
  assign s_axi.arcache = 4'd0;
  assign s_axi.arprot  = 3'd0;
  assign s_axi.arqos   = 4'd0;
  assign s_axi.arvalid = arvalid_q;

  assign s_axi.rready  = rready;
  assign o_rdata       = s_axi.rdata;
  assign o_rvalid      = s_axi.rvalid && rready;
  assign o_rlast       = s_axi.rlast;

  // Response IDs are always 0 since only ID 0 is ever issued.
  logic unused_ids;
  assign unused_ids = ^{s_axi.bid, s_axi.rid};

endmodule
